uart_rx_deser: RTL
==================

UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, gives the clk cycles per UART bit (115200 baud at 100 MHz); legal range is 4 or more.
REQ-002 Parameter DATA_BITS, default 8, gives the data bits per frame; legal range is 5 to 8.
REQ-003 Port clk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 Port rx_i, input, 1 bit: the raw UART RX line from the IO pad, asynchronous to clk, idle high.
REQ-006 Port rx_data_o, output, DATA_BITS wide: the received byte, LSB = first data bit.
REQ-007 Port rx_valid_o, output, 1 bit: rx_data_o holds an unconsumed byte.
REQ-008 Port rx_ready_i, input, 1 bit: the consumer accepts a byte when rx_valid_o and rx_ready_i are both high.
REQ-009 Port frame_err_o, output, 1 bit: a one-cycle pulse when the stop bit is sampled low.
REQ-010 Port overrun_o, output, 1 bit: a one-cycle pulse when a new byte is dropped because the holding register is full.
REQ-011 Port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-012 rx_i passes through a 2-flop synchronizer (rx_s) whose flops reset to 1; the FSM observes only rx_s.
REQ-013 FSM states: WAIT_HIGH, IDLE, START, DATA, STOP; one bit counter cnt and one bit index idx.
REQ-014 WAIT_HIGH goes to IDLE when rx_s=1.
REQ-015 IDLE goes to START with cnt=0 when rx_s=0.
REQ-016 START increments cnt; at cnt=CLKS_PER_BIT/2-1, if rx_s=0 go to DATA with cnt=0, idx=0; if rx_s=1 (glitch) go to IDLE.
REQ-017 DATA increments cnt; at cnt=CLKS_PER_BIT-1, shift rx_s into the shift register LSB-first, clear cnt, and increment idx; after sample DATA_BITS-1, go to STOP.
REQ-018 STOP increments cnt; at cnt=CLKS_PER_BIT-1, if rx_s=1 the byte is complete and the FSM goes to IDLE.
REQ-019 In STOP at the same sample point, if rx_s=0, pulse frame_err_o, discard the byte, and go to WAIT_HIGH (break/line-low handling).
REQ-020 On byte completion with rx_valid_o=0: load rx_data_o and set rx_valid_o on the next cycle.
REQ-021 On byte completion with rx_valid_o=1 and rx_ready_i=1 in the same cycle: replace rx_data_o, keep rx_valid_o=1, and do not pulse overrun_o.
REQ-022 On byte completion with rx_valid_o=1 and rx_ready_i=0: keep the old data, drop the new byte, and pulse overrun_o.
REQ-023 When rx_valid_o and rx_ready_i are high and no byte completes that cycle, rx_valid_o falls on the next cycle; rx_data_o keeps its last value.
REQ-024 While rx_valid_o=1 and rx_ready_i=0, rx_data_o is stable.
REQ-025 Latency from the rx_i falling edge of the start bit to rx_valid_o rising is 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles, ±1 cycle.
REQ-026 rx_ready_i has no effect while rx_valid_o=0.
REQ-027 frame_err_o and overrun_o are never asserted in the same cycle.

Reset
REQ-028 When rst_n=0, the FSM is in WAIT_HIGH, cnt=0, idx=0, shift register=0, rx_data_o=0, rx_valid_o=0, frame_err_o=0, overrun_o=0, busy_o=1.
REQ-029 Reset asserted mid-frame aborts the frame immediately; the partial byte is never presented.
REQ-030 After reset release, reception starts only after rx_s has been seen high at least once.

Verification
REQ-031 Idle-high line, then frame 0x55 with CLKS_PER_BIT=868 and rx_ready_i=1 -> rx_valid_o pulses for 1 cycle with rx_data_o=0x55 at the REQ-025 latency; no error pulses.
REQ-032 rx_i low for 200 cycles, then high -> no rx_valid_o and no frame_err_o; busy_o returns to 0 within 2+434 cycles of the falling edge.
REQ-033 Frame 0xA5 with a low stop bit held low for 3 bit times, then high, then frame 0x3C -> one frame_err_o pulse and no byte for 0xA5; then rx_data_o=0x3C valid.
REQ-034 rx_ready_i=0; frames 0x11 then 0x22 -> rx_valid_o=1 with rx_data_o=0x11 held, overrun_o pulses once at the 0x22 stop sample; raising rx_ready_i for 1 cycle -> rx_valid_o drops.
REQ-035 rx_valid_o=1 holding 0x11; rx_ready_i pulsed exactly in the 0x22 completion cycle -> rx_valid_o stays 1, rx_data_o=0x22, and overrun_o=0.
REQ-036 rst_n pulsed low during data bit 4 with rx_i held low -> all outputs at reset values; no byte until rx_i goes high; the next frame 0xF0 is received correctly.

Source files
------------

// File: rtl/uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_deser
// Brief   : UART receiver with 2-flop input synchronizer, mid-bit sampling,
//           one-deep holding register, frame-error and overrun pulses.
// Rev     : 1.0  initial release
// ============================================================================
module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] c_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_WAIT_HIGH = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_STOP      = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [1:0]           r_primed;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  // The synchronizer resets to 1, so its first two outputs after reset are
  // not real line samples; r_primed keeps WAIT_HIGH from trusting them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_primed  <= 2'b00;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
      r_primed  <= {r_primed[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT_HIGH;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_valid && rx_ready_i) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        S_WAIT_HIGH: begin
          if (r_rx_s && r_primed[1]) begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == c_HALF_M1) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == c_FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            r_idx   <= r_idx + IDX_W'(1);
            if (r_idx == c_LAST_IDX) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == c_FULL_M1) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
              // A same-cycle consume frees the holding register for this byte.
              if (!r_valid || rx_ready_i) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_WAIT_HIGH;
      endcase
    end
  end

  assign rx_data_o   = r_data;
  assign rx_valid_o  = r_valid;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;
  assign busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire
